input_port_ctrl: RTL
====================

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable cycles required to accept an input change; legal range 1..255.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on every raw input; legal range 2..3.
REQ-003 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s_button  input  1  raw, asynchronous step pushbutton.
REQ-006 switch_in  input  4  raw, asynchronous slide switches switch3..switch0.
REQ-007 rd_req  input  1  CPU read request, level, synchronous to clk.
REQ-008 rd_ack  output  1  one-cycle read acknowledge.
REQ-009 rd_data  output  16  captured port word.
REQ-010 event_pending  output  1  high while one or more unread button presses exist.
REQ-011 s_level  output  1  debounced button level.

Function
REQ-012 Each of the 5 raw inputs SHALL pass through SYNC_STAGES flops, then an independent debounce cell.
REQ-013 Debounce cell: 8-bit counter SHALL increment each cycle the synchronized value differs from the stable value, clear when it matches, and on reaching DEBOUNCE_CYCLES update the stable value and clear.
REQ-014 Latency from raw change (held) to stable-value change SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles; pulses shorter than DEBOUNCE_CYCLES synchronized cycles SHALL be ignored.
REQ-015 A 0->1 transition of stable s_button SHALL increment a 3-bit event_count, saturating at 7.
REQ-016 event_pending SHALL equal (event_count != 0).
REQ-017 rd_data layout: [15:8] = 0, [7:5] = event_count, [4] = s_level, [3:0] = stable switches.
REQ-018 Read FSM states: IDLE, ACK, WAIT_LOW.
REQ-019 IDLE with rd_req=1: capture rd_data, clear event_count, go to ACK.
REQ-020 ACK: rd_ack=1 for exactly this one cycle; go to WAIT_LOW if rd_req=1, else IDLE.
REQ-021 WAIT_LOW: go to IDLE when rd_req=0; no capture while in WAIT_LOW (one ack per request level).
REQ-022 rd_ack latency SHALL be exactly 1 cycle after rd_req sampled high in IDLE.
REQ-023 rd_data SHALL hold its captured value until the next capture.
REQ-024 Press edge in the capture cycle: captured count excludes it; event_count after capture SHALL be 1.
REQ-025 Saturated count (7) SHALL not wrap on further presses.

Reset
REQ-026 reset_n=0 SHALL immediately force: rd_ack=0, rd_data=0, event_pending=0, s_level=0, event_count=0, all sync flops, stable values and debounce counters 0, FSM=IDLE.
REQ-027 Reset asserted mid-transaction (ACK or WAIT_LOW) SHALL abort it with no ack.
REQ-028 Deassertion SHALL be taken synchronously to clk; first capture possible on the first clock edge after deassertion.

Structure
REQ-029 Shared package input_port_pkg SHALL hold the FSM state type, rd_data field position constants, and the count width constant.
REQ-030 Sub-module debounce_cell (sync chain + counter + stable flop), instantiated 5 times.
REQ-031 No combinational path from raw inputs to any output.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-032 reset_n=0 mid-ACK -> rd_ack=0, rd_data=0x0000, event_pending=0 without a clock edge.
REQ-033 switch_in=4'b0100 held -> stable bit set exactly 6 cycles later; read -> rd_data=0x0004.
REQ-034 s_button high 3 cycles then low -> event_pending stays 0; read -> rd_data=0x0000.
REQ-035 s_button high 10 cycles, released, then read -> rd_data=0x0020, rd_ack one cycle after rd_req, event_pending 0 after ack.
REQ-036 9 separate presses, no read -> read returns rd_data[7:5]=7; press coincident with capture cycle -> event_count=1 afterwards.
REQ-037 rd_req held high 5 cycles -> exactly one rd_ack pulse; next rd_req after low -> second ack.

Source files
------------

// File: rtl/input_port_pkg.sv
// Shared types and field positions for the input port controller:
// read FSM state encoding, rd_data word layout and counter widths.
package input_port_pkg;

    localparam int DATA_W    = 16;
    localparam int SW_W      = 4;
    localparam int COUNT_W   = 3;
    localparam int DEB_CNT_W = 8;

    localparam int SW_LSB    = 0;
    localparam int LEVEL_BIT = 4;
    localparam int COUNT_LSB = 5;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_ACK      = 2'd1,
        RD_WAIT_LOW = 2'd2
    } rd_state_e;

    function automatic logic [DATA_W-1:0] pack_word(
        input logic [COUNT_W-1:0] cnt,
        input logic               lvl,
        input logic [SW_W-1:0]    sw
    );
        logic [DATA_W-1:0] w;
        w                       = '0;
        w[COUNT_LSB +: COUNT_W] = cnt;
        w[LEVEL_BIT]            = lvl;
        w[SW_LSB +: SW_W]       = sw;
        return w;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One raw asynchronous input: SYNC_STAGES-deep synchronizer, then a counter
// that only accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_cell
    import input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic stable_o,
    output logic rise_o
);

    localparam logic [DEB_CNT_W-1:0] LAST_CNT = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_val;
    logic                   accept;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
        cnt_d    = '0;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync_val != stable_q) begin
            if (cnt_q == LAST_CNT) begin
                accept   = 1'b1;
                stable_d = sync_val;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Strobe on the same edge the stable value goes 0->1, so the event
    // counter moves together with the level it reports.
    assign rise_o   = accept & sync_val;
    assign stable_o = stable_q;

endmodule

// File: rtl/input_port_ctrl.sv
// Debounced button/switch input port with a press-event counter, read by a CPU
// through a level request and a one-cycle acknowledge.
module input_port_ctrl
    import input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_button,
    input  logic [SW_W-1:0]   switch_in,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              event_pending,
    output logic              s_level,
    output rd_state_e         dbg_state
);

    localparam int N_IN = SW_W + 1;

    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] stable;
    logic [N_IN-1:0] rise;
    logic            unused_rise;

    assign raw_in = {s_button, switch_in};

    for (genvar i = 0; i < N_IN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_in  (raw_in[i]),
            .stable_o(stable[i]),
            .rise_o  (rise[i])
        );
    end

    assign unused_rise = ^rise[SW_W-1:0];

    // Read handshake: rd_req is a level. A high rd_req sampled in IDLE captures
    // the port word; rd_ack is high for exactly the next cycle. The FSM then
    // waits for rd_req to drop, so one request level yields one acknowledge.
    rd_state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= RD_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:     if (rd_req) state_d = RD_ACK;
            RD_ACK:      state_d = rd_req ? RD_WAIT_LOW : RD_IDLE;
            RD_WAIT_LOW: if (!rd_req) state_d = RD_IDLE;
            default:     state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_ack = (state_q == RD_ACK);
    end

    logic [COUNT_W-1:0] event_count_q, event_count_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               capture;
    logic               btn_rise;

    assign capture  = (state_q == RD_IDLE) && rd_req;
    assign btn_rise = rise[N_IN-1];

    // A press landing on the capture edge is not in the captured word;
    // it survives as the first event of the next read.
    always_comb begin
        event_count_d = event_count_q;
        rd_data_d     = rd_data_q;
        if (capture) begin
            rd_data_d     = pack_word(event_count_q, stable[N_IN-1], stable[SW_W-1:0]);
            event_count_d = btn_rise ? COUNT_W'(1) : '0;
        end else if (btn_rise && (event_count_q != COUNT_MAX)) begin
            event_count_d = event_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_count_q <= '0;
            rd_data_q     <= '0;
        end else begin
            event_count_q <= event_count_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign event_pending = (event_count_q != '0);
    assign s_level       = stable[N_IN-1];
    assign dbg_state     = state_q;

endmodule
